mc_control_regs: RTL
====================

Name: mc_control_regs

Overview:
- Sequential register bank sitting directly downstream of the multicycle control PLA.
- Holds the 4-bit control state fed back to the PLA, plus the architectural and temporary datapath registers that the PLA's control outputs write: PC, IR, MDR, A, B and ALUOut.
- Supplies CurrentState and Op back to the PLA, closing the multicycle control loop.

Parameters:
- WIDTH, 32, datapath word width in bits (PC, IR, MDR, A, B, ALUOut).
- RESET_PC, 32'h0000_0000, value loaded into PC on reset.
- NUM_STATES, 10, number of legal control states (0..NUM_STATES-1); state 0 is fetch.

Ports:
- clk  in  1  system clock, all registers update on rising edge
- reset  in  1  synchronous, active-high reset
- NS  in  4  next state from the PLA ({NS3,NS2,NS1,NS0})
- PCWrite  in  1  unconditional PC write enable
- PCWriteCond  in  1  PC write enable qualified by Zero
- IRWrite  in  1  IR load enable
- PCSource  in  2  {PCSource1,PCSource0}; PC next-value select
- Zero  in  1  ALU zero flag, same cycle
- ALUResult  in  WIDTH  combinational ALU output
- MemData  in  WIDTH  memory read data
- RegA  in  WIDTH  register file read port 1
- RegB  in  WIDTH  register file read port 2
- CurrentState  out  4  registered control state to the PLA
- Op  out  6  IR[31:26], to the PLA
- PC  out  WIDTH  program counter
- IR  out  WIDTH  instruction register
- MDR  out  WIDTH  memory data register
- A  out  WIDTH  latched RegA
- B  out  WIDTH  latched RegB
- ALUOut  out  WIDTH  latched ALUResult
- illegal_state  out  1  sticky flag: CurrentState was ever >= NUM_STATES
- retired  out  32  count of completed instructions

Behaviour:
- Reset (synchronous, active-high, takes priority over everything):
  - CurrentState=0, PC=RESET_PC.
  - IR, MDR, A, B, ALUOut = 0.
  - illegal_state=0, retired=0.
  - Reset asserted mid-instruction aborts it; no partial writes happen in the reset cycle.
- State register:
  - Legal state (CurrentState < NUM_STATES): CurrentState <= NS every cycle.
  - Illegal state (CurrentState >= NUM_STATES): next state forced to 0 regardless of NS, illegal_state set, and PC/IR writes suppressed in that cycle.
  - NS >= NUM_STATES from a legal state is accepted; recovery happens on the following cycle.
- Op = IR[31:26], combinational from IR. Changes the cycle after an IRWrite edge.
- PC write enable pc_we = (PCWrite | (PCWriteCond & Zero)) & legal state. Both enables high is still a single write.
- PC next value, selected by PCSource:
  - 00: ALUResult
  - 01: ALUOut (value before this edge)
  - 10: jump target {PC[31:28], IR[25:0], 2'b00}, using current PC and IR
  - 11: reserved; PC holds even if pc_we=1.
- IR <= MemData when IRWrite & legal state; otherwise holds.
- MDR, A, B, ALUOut load MemData, RegA, RegB, ALUResult unconditionally every cycle (one-cycle temporaries), including in illegal states.
- retired increments by 1 on every legal transition from CurrentState != 0 to NS == 0. It wraps 32'hFFFF_FFFF -> 0. The forced return from an illegal state does not count.
- Latency: every output is registered, one cycle after its inputs. Op and the jump target are combinational from the registered IR/PC.

Decomposition:
- Shared package: state encodings (S_FETCH=0 .. S_JR_COMPLETE=9, matching the PLA), PCSource codes (PCSRC_ALU, PCSRC_ALUOUT, PCSRC_JUMP, PCSRC_RSVD), opcode field bit positions.
- One natural sub-module, mc_pc_unit: PC register, pc_we qualification, PCSource mux and jump-target formation.

Test Plan:
- Reset with RESET_PC=32'h0000_0040, drive NS=4'h5 during reset -> after reset release: PC=0x40, CurrentState=0, IR=0, retired=0, illegal_state=0.
- Fetch: state 0, PCWrite=1, PCSource=00, ALUResult=0x44, IRWrite=1, MemData=0x8C22_0004 -> next cycle: PC=0x44, IR=0x8C22_0004, Op=6'h23, CurrentState=NS.
- Branch: PCWriteCond=1, PCSource=01, ALUOut=0x100, Zero=0 -> PC unchanged. Repeat with Zero=1 -> PC=0x100. Repeat with PCWrite=1 and PCWriteCond=1, Zero=1 -> single write, PC=0x100.
- Jump: PC=0xA000_0010, IR[25:0]=26'h0000_123, PCSource=10, PCWrite=1 -> PC=0xA000_048C. PCSource=11 with PCWrite=1 -> PC holds.
- Illegal state: force NS=4'hC from state 1 -> CurrentState=12 for one cycle, during which PCWrite/IRWrite are ignored. Next cycle CurrentState=0 and illegal_state=1 (sticky), retired unchanged.
- Retire count and reset mid-op:
  - Run 3 full instructions -> retired=3.
  - Preload retired=32'hFFFF_FFFF, complete one instruction -> retired=0.
  - Assert reset while in state 3 -> all registers return to reset values on the next edge.

Source files
------------

// File: rtl/mc_control_regs_pkg.sv
// Shared encodings for the multicycle control register bank.
// Control state codes match the control PLA; PCSource codes select the PC next value.
// Also holds the opcode and jump-index field positions within IR.
package mc_control_regs_pkg;

  typedef enum logic [3:0] {
    S_FETCH       = 4'd0,
    S_DECODE      = 4'd1,
    S_MEM_ADDR    = 4'd2,
    S_MEM_READ    = 4'd3,
    S_MEM_WB      = 4'd4,
    S_MEM_WRITE   = 4'd5,
    S_EXECUTE     = 4'd6,
    S_R_COMPLETE  = 4'd7,
    S_BRANCH      = 4'd8,
    S_JR_COMPLETE = 4'd9
  } state_e;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10,
    PCSRC_RSVD   = 2'b11
  } pcsrc_e;

  // Opcode field within IR, fed back to the PLA.
  localparam int OP_MSB = 31;
  localparam int OP_LSB = 26;
  // Jump index field within IR.
  localparam int JIDX_MSB = 25;

endpackage

// File: rtl/mc_control_regs_pc_unit.sv
// Program counter: write qualification, next-value select and jump-target formation.
// Latency: PC updates one cycle after its enables; jump target is combinational from PC/IR.
// No backpressure: writes happen on the edge whenever the qualified enable is high.
module mc_pc_unit
  import mc_control_regs_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             legal,
  input  logic             pc_write,
  input  logic             pc_write_cond,
  input  logic             zero,
  input  logic [1:0]       pc_source,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [WIDTH-1:0] alu_out,
  input  logic [WIDTH-1:0] ir,
  output logic [WIDTH-1:0] pc
);

  logic             pc_we;
  logic [WIDTH-1:0] jump_tgt;
  logic [WIDTH-1:0] pc_nxt;

  // Qualify the write and pick the next PC; the reserved code simply holds PC.
  always_comb begin
    pc_we    = (pc_write | (pc_write_cond & zero)) & legal;
    jump_tgt = {pc[WIDTH-1:28], ir[JIDX_MSB:0], 2'b00};
    pc_nxt   = pc;
    case (pcsrc_e'(pc_source))
      PCSRC_ALU:    pc_nxt = alu_result;
      PCSRC_ALUOUT: pc_nxt = alu_out;
      PCSRC_JUMP:   pc_nxt = jump_tgt;
      default:      pc_nxt = pc;
    endcase
  end

  // PC register; reset wins over any pending write.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (pc_we) begin
      pc <= pc_nxt;
    end
  end

endmodule

// File: rtl/mc_control_regs.sv
// Multicycle control state register plus PC/IR/MDR/A/B/ALUOut datapath registers.
// Latency: all outputs registered one cycle after inputs; Op is combinational from IR.
// No backpressure: every register samples on each rising edge.
module mc_control_regs
  import mc_control_regs_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_PC   = '0,
  parameter int               NUM_STATES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       NS,
  input  logic             PCWrite,
  input  logic             PCWriteCond,
  input  logic             IRWrite,
  input  logic [1:0]       PCSource,
  input  logic             Zero,
  input  logic [WIDTH-1:0] ALUResult,
  input  logic [WIDTH-1:0] MemData,
  input  logic [WIDTH-1:0] RegA,
  input  logic [WIDTH-1:0] RegB,
  output logic [3:0]       CurrentState,
  output logic [5:0]       Op,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] IR,
  output logic [WIDTH-1:0] MDR,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] ALUOut,
  output logic             illegal_state,
  output logic [31:0]      retired
);

  // One extra bit so NUM_STATES == 16 still compares correctly.
  localparam logic [4:0] NS_LIMIT = 5'(NUM_STATES);

  state_e      state_q;
  state_e      state_nxt;
  logic        legal;
  logic        retire;
  logic [31:0] retired_q;
  logic        illegal_q;

  assign legal = ({1'b0, state_q} < NS_LIMIT);

  // Next state: follow the PLA from a legal state, otherwise fall back to fetch.
  always_comb begin
    state_nxt = S_FETCH;
    retire    = 1'b0;
    if (legal) begin
      state_nxt = state_e'(NS);
      retire    = (state_q != S_FETCH) && (NS == S_FETCH);
    end
  end

  // Control state, sticky illegal flag and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_nxt;
      if (!legal) begin
        illegal_q <= 1'b1;
      end
      if (retire) begin
        retired_q <= retired_q + 32'd1;
      end
    end
  end

  // IR loads only when requested from a legal state.
  always_ff @(posedge clk) begin
    if (reset) begin
      IR <= '0;
    end else if (IRWrite && legal) begin
      IR <= MemData;
    end
  end

  // One-cycle temporaries: reloaded every cycle, even from an illegal state.
  always_ff @(posedge clk) begin
    if (reset) begin
      MDR    <= '0;
      A      <= '0;
      B      <= '0;
      ALUOut <= '0;
    end else begin
      MDR    <= MemData;
      A      <= RegA;
      B      <= RegB;
      ALUOut <= ALUResult;
    end
  end

  mc_pc_unit #(
    .WIDTH    (WIDTH),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk           (clk),
    .reset         (reset),
    .legal         (legal),
    .pc_write      (PCWrite),
    .pc_write_cond (PCWriteCond),
    .zero          (Zero),
    .pc_source     (PCSource),
    .alu_result    (ALUResult),
    .alu_out       (ALUOut),
    .ir            (IR),
    .pc            (PC)
  );

  assign CurrentState  = state_q;
  assign Op            = IR[OP_MSB:OP_LSB];
  assign illegal_state = illegal_q;
  assign retired       = retired_q;

endmodule
